dac_gpio_scheduler: RTL and testbench

DAC_GPIO_SCHEDULER -- requirements
Module: dac_gpio_scheduler

---
 rtl/dac_gpio_scheduler.sv | 155 +++++++++++++++
 tb/tb_dac_gpio_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_gpio_scheduler.sv
// Two-requester write scheduler that serialises register writes onto a DAC-driver GPIO bus.
// Each write is framed as setup / strobe / hold phases; the w_clk strobe comes straight from a flop.
`timescale 1ns/1ps
module dac_gpio_scheduler #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] gpio_out,
  output logic        busy,
  output logic        grant,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        wclk_q;
  logic        busy_q;
  logic        grant_q;
  logic        last_q;
  logic [15:0] wr_count_q;

  logic        sel_s;
  logic        accept_s;
  logic [15:0] addr_d;
  logic [7:0]  data_d;
  logic [15:0] wr_count_d;

  // Arbiter: a lone requester wins; on contention the one not served last time wins.
  always_comb begin
    sel_s = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_s = ~last_q;
    end else if (req1_valid) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Acceptance is qualified by rst so both readies stay low while the block is held in reset.
  always_comb begin
    accept_s = 1'b0;
    addr_d   = req0_addr;
    data_d   = req0_data;
    if (rst && (state_q == IDLE) && (req0_valid || req1_valid)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (sel_s) begin
      addr_d = req1_addr;
      data_d = req1_data;
    end else begin
      addr_d = req0_addr;
      data_d = req0_data;
    end
    wr_count_d = wr_count_q + 16'd1;
  end

  assign req0_ready = accept_s & ~sel_s;
  assign req1_ready = accept_s &  sel_s;

  // Write-framing FSM; phase counter is reloaded with (length - 1) on every state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'd0;
      data_q     <= 8'd0;
      wclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      wr_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            grant_q <= sel_s;
            last_q  <= sel_s;
            cnt_q   <= SETUP_LD;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= STROBE_LD;
            wclk_q  <= 1'b1;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= HOLD_LD;
            wclk_q  <= 1'b0;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            busy_q     <= 1'b0;
            wr_count_q <= wr_count_d;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          wclk_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gpio_out = {7'd0, wclk_q, data_q, addr_q};
  assign busy     = busy_q;
  assign grant    = grant_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dac_gpio_scheduler.sv
// Self-checking bench for dac_gpio_scheduler: vector table, directed corner cases and a
// randomized run compared against a timeline-based reference model.
`timescale 1ns/1ps
module tb_dac_gpio_scheduler;

  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, r0, r1, busy, grant;
  logic [15:0] a0, a1, wcnt;
  logic [7:0]  d0, d1;
  logic [31:0] gpio;

  logic        p_v0, p_v1, p_r0, p_r1, p_busy, p_grant;
  logic [15:0] p_a0, p_a1, p_wcnt;
  logic [7:0]  p_d0, p_d1;
  logic [31:0] p_gpio;

  dac_gpio_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .gpio_out(gpio), .busy(busy), .grant(grant), .wr_count(wcnt)
  );

  dac_gpio_scheduler #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(15)) dut_p (
    .clk(clk), .rst(rst),
    .req0_valid(p_v0), .req0_addr(p_a0), .req0_data(p_d0), .req0_ready(p_r0),
    .req1_valid(p_v1), .req1_addr(p_a1), .req1_data(p_d1), .req1_ready(p_r1),
    .gpio_out(p_gpio), .busy(p_busy), .grant(p_grant), .wr_count(p_wcnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write is a window of S+ST+H busy cycles; m_pos is the offset into it.
  int          m_left, m_pos;
  logic [15:0] m_addr, m_cnt;
  logic [7:0]  m_data;
  logic        m_grant, m_last, e_r0, e_r1;

  task automatic model_reset();
    m_left = 0; m_pos = 0; m_addr = 16'd0; m_data = 8'd0;
    m_grant = 1'b0; m_last = 1'b1; m_cnt = 16'd0;
  endtask

  function automatic logic [31:0] exp_gpio();
    logic w;
    w = (m_left > 0) && (m_pos >= S) && (m_pos < S + ST);
    return {7'd0, w, m_data, m_addr};
  endfunction

  task automatic model_check();
    logic sel;
    logic idle;
    idle = (m_left == 0) && (rst === 1'b1);
    sel  = (v0 && v1) ? ~m_last : v1;
    e_r0 = idle && (v0 || v1) && !sel;
    e_r1 = idle && (v0 || v1) && sel;
    chk("ready0", 32'(r0), 32'(e_r0));
    chk("ready1", 32'(r1), 32'(e_r1));
    chk("gpio", gpio, exp_gpio());
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("wr_count", 32'(wcnt), 32'(m_cnt));
  endtask

  task automatic model_step();
    if (e_r0 || e_r1) begin
      m_addr  = e_r1 ? a1 : a0;
      m_data  = e_r1 ? d1 : d0;
      m_grant = e_r1;
      m_last  = e_r1;
      m_left  = S + ST + H;
      m_pos   = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_pos++;
      if (m_left == 0) m_cnt++;
    end
  endtask

  task automatic drive(input logic iv0, input logic [15:0] ia0, input logic [7:0] id0,
                       input logic iv1, input logic [15:0] ia1, input logic [7:0] id1);
    v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        v0;
    logic [15:0] a;
    logic [7:0]  d;
    logic        er0;
    logic [31:0] eg;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[10];
  int   acc_q[$];
  int   nacc, last_acc, idx, len;
  logic acc_p[45];
  logic w_p[45];
  logic b_p[45];

  initial begin
    tbl[0] = '{1'b1, 16'd3, 8'h02, 1'b1, 32'h0000_0000, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 16'd0, 8'h00, 1'b0, 32'h0002_0003, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 16'd0, 8'h00, 1'b0, 32'h0102_0003, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 16'd0, 8'h00, 1'b0, 32'h0102_0003, 1'b1, 16'd0};
    for (int i = 4; i < 9; i++) tbl[i] = '{1'b0, 16'd0, 8'h00, 1'b0, 32'h0002_0003, 1'b1, 16'd0};
    tbl[9] = '{1'b0, 16'd0, 8'h00, 1'b0, 32'h0002_0003, 1'b0, 16'd1};

    p_v0 = 1'b0; p_a0 = 16'd0; p_d0 = 8'd0; p_v1 = 1'b0; p_a1 = 16'd0; p_d1 = 8'd0;
    rst = 1'b0;
    model_reset();

    // Reset state with both requesters asking: nothing may be ready.
    drive(1'b1, 16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF);
    model_check();
    @(posedge clk); @(negedge clk);
    model_check();
    drive(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    rst = 1'b1;
    #1;

    // Single write waveform from the vector table.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v0, tbl[i].a, tbl[i].d, 1'b0, 16'd0, 8'd0);
      model_check();
      chk("tbl_ready0", 32'(r0), 32'(tbl[i].er0));
      chk("tbl_gpio", gpio, tbl[i].eg);
      chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
      chk("tbl_wcnt", 32'(wcnt), 32'(tbl[i].ec));
      advance();
    end

    // Reset in the second strobe cycle: strobe and bus must clear without a clock edge.
    drive(1'b1, 16'h0010, 8'h77, 1'b0, 16'd0, 8'd0);
    model_check();
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);
      model_check();
      advance();
    end
    drive(1'b1, 16'h0020, 8'h11, 1'b1, 16'h0021, 8'h22);
    chk("strobe_before_rst", 32'(gpio[24]), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_wclk", 32'(gpio[24]), 32'd0);
    chk("rst_gpio", gpio, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wcnt", 32'(wcnt), 32'd0);
    chk("rst_ready0", 32'(r0), 32'd0);
    chk("rst_ready1", 32'(r1), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Contention after reset: grants alternate starting with requester 0, 9 cycles apart.
    nacc = 0; last_acc = 0;
    for (int c = 0; c < 54; c++) begin
      drive(1'b1, 16'($urandom), 8'($urandom), 1'b1, 16'($urandom), 8'($urandom));
      model_check();
      if (r0 || r1) begin
        chk("cont_grant", 32'(r1), 32'(nacc % 2));
        if (nacc > 0) chk("cont_spacing", 32'(c - last_acc), 32'(1 + S + ST + H));
        last_acc = c;
        nacc++;
      end
      advance();
    end
    drive(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    model_check();
    chk("cont_nacc", 32'(nacc), 32'd6);
    chk("cont_wcnt", 32'(wcnt), 32'd6);
    advance();

    // Requester inputs change while the write is in flight: bus keeps the accepted values.
    drive(1'b1, 16'h0042, 8'hAA, 1'b0, 16'd0, 8'd0);
    model_check();
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h0099, 8'h55, 1'b0, 16'd0, 8'd0);
      model_check();
      chk("late_data", 32'(gpio[23:16]), 32'h0000_00AA);
      chk("late_addr", 32'(gpio[15:0]), 32'h0000_0042);
      advance();
    end
    drive(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    model_check();
    advance();

    // Randomized traffic including requests withdrawn before acceptance.
    for (int c = 0; c < 400; c++) begin
      drive(1'(($urandom % 3) != 0), 16'($urandom), 8'($urandom),
            1'(($urandom % 3) != 0), 16'($urandom), 8'($urandom));
      model_check();
      advance();
    end
    drive(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);

    // Non-default phase lengths 3/1/15 on the second instance.
    for (int c = 0; c < 45; c++) begin
      p_v0 = 1'b1; p_a0 = 16'h1234; p_d0 = 8'(c);
      #1;
      acc_p[c] = p_r0;
      w_p[c]   = p_gpio[24];
      b_p[c]   = p_busy;
      @(posedge clk); @(negedge clk);
    end
    p_v0 = 1'b0;
    #1;
    chk("p_wcnt", 32'(p_wcnt), 32'd2);
    for (int c = 0; c < 45; c++) if (acc_p[c]) acc_q.push_back(c);
    chk("p_nacc", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 2) begin
      chk("p_spacing", 32'(acc_q[1] - acc_q[0]), 32'd20);
      idx = acc_q[0] + 1;
      len = 0;
      while (idx < 45 && b_p[idx] && !w_p[idx]) begin len++; idx++; end
      chk("p_setup_len", 32'(len), 32'd3);
      len = 0;
      while (idx < 45 && b_p[idx] && w_p[idx]) begin len++; idx++; end
      chk("p_strobe_len", 32'(len), 32'd1);
      len = 0;
      while (idx < 45 && b_p[idx] && !w_p[idx]) begin len++; idx++; end
      chk("p_hold_len", 32'(len), 32'd15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
